// File: rtl/blit_stop_pkg.sv
// Shared encodings for the blitter collision-stop controller: FSM states,
// control-word bit positions and status-word bit positions.
package blit_stop_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_STOPPED = 2'd1;
  localparam state_t ST_ABORT   = 2'd2;

  localparam int RESUME_B = 0;
  localparam int ABORT_B  = 1;
  localparam int EN_LSB   = 2;

  localparam int STAT_STOPPED  = 0;
  localparam int STAT_ABORTING = 1;
  localparam int CAUSE_LSB     = 2;
  localparam int CNT_LSB       = 16;

  // The blitter is held off in both STOPPED and ABORT.
  function automatic logic is_halted(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/blit_coll_edge.sv
// One collision channel: qualifies the comparator nowrite term with its
// enable and the write phase, and produces a single-cycle rising edge.
module blit_coll_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clk_en,
  input  logic i_req,
  input  logic i_en,
  input  logic i_dwrite,
  output logic o_edge
);

  logic w_hit;
  logic r_hit_d;

  assign w_hit = i_req & i_en & i_dwrite;

  // The delayed copy keeps tracking in every state so a held hit never re-fires.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit_d <= 1'b0;
    end else if (i_clk_en) begin
      r_hit_d <= w_hit;
    end
  end

  assign o_edge = w_hit & ~r_hit_d;

endmodule

// File: rtl/blit_coll_stop_ctrl.sv
// Blitter collision-stop controller: per-channel sticky causes, saturating
// collision counter and a multi-cycle engine abort. Optional interrupt
// output and mask bit are built when COLL_IRQ_EN is defined.
module blit_coll_stop_ctrl
  import blit_stop_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int ABORT_LEN = 2,
  parameter int DATA_W    = 32
) (
  input  logic              i_sys_clk,
  input  logic              i_xreset,
  input  logic              i_clk_en,
  input  logic [NCH-1:0]    i_coll_req,
  input  logic              i_dwrite,
  input  logic [DATA_W-1:0] i_gpu_din,
  input  logic              i_stopld,
  input  logic              i_statrd,
  output logic [DATA_W-1:0] o_stat_dout,
  output logic              o_stat_oe,
  output logic              o_stopped,
  output logic              o_eng_reset,
`ifdef COLL_IRQ_EN
  output logic              o_coll_irq,
`endif
  output logic [CNT_W-1:0]  o_coll_count
);

  localparam int CLR_B  = EN_LSB + NCH;
  localparam int MASK_B = CLR_B + 1;
  localparam int TMR_W  = (ABORT_LEN > 1) ? $clog2(ABORT_LEN) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ABORT_LEN - 1);

  state_t            r_state;
  logic [NCH-1:0]    r_en;
  logic [NCH-1:0]    r_cause;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [NCH-1:0]    w_edge;
  logic              w_any;
  logic              w_resume;
  logic              w_abort;
  logic              w_clr;
  logic              w_inc;
  logic              w_aborting;
  logic [DATA_W-1:0] w_stat;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    blit_coll_edge u_edge (
      .i_clk    (i_sys_clk),
      .i_reset  (i_xreset),
      .i_clk_en (i_clk_en),
      .i_req    (i_coll_req[g]),
      .i_en     (r_en[g]),
      .i_dwrite (i_dwrite),
      .o_edge   (w_edge[g])
    );
  end

  assign w_any    = |w_edge;
  assign w_resume = i_stopld & i_gpu_din[RESUME_B];
  assign w_abort  = i_stopld & i_gpu_din[ABORT_B];
  assign w_clr    = i_stopld & i_gpu_din[CLR_B];
  assign w_inc    = (r_state == ST_IDLE) & w_any;

  // Only IDLE reacts to edges; STOPPED takes commands, ABORT runs its timer.
  always_ff @(posedge i_sys_clk) begin
    if (i_xreset) begin
      r_state <= ST_IDLE;
      r_cause <= '0;
      r_timer <= '0;
    end else if (i_clk_en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_STOPPED;
            r_cause <= w_edge;
          end
        end
        ST_STOPPED: begin
          if (w_abort) begin
            r_state <= ST_ABORT;
            r_timer <= '0;
          end else if (w_resume) begin
            r_state <= ST_IDLE;
            r_cause <= '0;
          end
        end
        ST_ABORT: begin
          if (r_timer == TMR_LAST) begin
            r_state <= ST_IDLE;
            r_cause <= '0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cause <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Enables reload on every control write; clear beats a same-cycle increment.
  always_ff @(posedge i_sys_clk) begin
    if (i_xreset) begin
      r_en  <= '0;
      r_cnt <= '0;
    end else if (i_clk_en) begin
      if (i_stopld) begin
        r_en <= i_gpu_din[EN_LSB +: NCH];
      end
      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_inc && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef COLL_IRQ_EN
  logic r_irq_mask;
  logic r_irq;

  always_ff @(posedge i_sys_clk) begin
    if (i_xreset) begin
      r_irq_mask <= 1'b0;
      r_irq      <= 1'b0;
    end else if (i_clk_en) begin
      if (i_stopld) begin
        r_irq_mask <= i_gpu_din[MASK_B];
      end
      r_irq <= w_inc & r_irq_mask;
    end
  end

  assign o_coll_irq = r_irq;
`endif

  assign w_aborting = (r_state == ST_ABORT);

  always_comb begin
    w_stat                     = '0;
    w_stat[STAT_STOPPED]       = is_halted(r_state);
    w_stat[STAT_ABORTING]      = w_aborting;
    w_stat[CAUSE_LSB +: NCH]   = r_cause;
    w_stat[CNT_LSB +: CNT_W]   = r_cnt;
`ifdef COLL_IRQ_EN
    w_stat[MASK_B]             = r_irq_mask;
`endif
  end

  assign o_stat_dout  = w_stat;
  assign o_stat_oe    = i_statrd;
  assign o_stopped    = is_halted(r_state);
  assign o_eng_reset  = i_xreset | w_aborting;
  assign o_coll_count = r_cnt;

endmodule

// File: tb/tb_blit_coll_stop_ctrl.sv
// Scoreboard bench for blit_coll_stop_ctrl (2-bit counter build): directed
// steps queue their expected status; a monitor compares after each edge.
module tb_blit_coll_stop_ctrl;

  localparam int NCH       = 4;
  localparam int CNT_W     = 2;
  localparam int ABORT_LEN = 2;
  localparam int DATA_W    = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              clkEn;
  logic [NCH-1:0]    collReq;
  logic              dWrite;
  logic [DATA_W-1:0] gpuDin;
  logic              stopLd;
  logic              statRead;
  logic [DATA_W-1:0] statDout;
  logic              statOe;
  logic              stopped;
  logic              engReset;
  logic [CNT_W-1:0]  collCount;
`ifdef COLL_IRQ_EN
  logic              collIrq;
`endif

  int checkCount = 0;
  int errorCount = 0;

  string             nameQ[$];
  logic [DATA_W-1:0] statQ[$];
  logic [1:0]        flagQ[$];

  blit_coll_stop_ctrl #(
    .NCH       (NCH),
    .CNT_W     (CNT_W),
    .ABORT_LEN (ABORT_LEN),
    .DATA_W    (DATA_W)
  ) dut (
    .i_sys_clk    (clock),
    .i_xreset     (reset),
    .i_clk_en     (clkEn),
    .i_coll_req   (collReq),
    .i_dwrite     (dWrite),
    .i_gpu_din    (gpuDin),
    .i_stopld     (stopLd),
    .i_statrd     (statRead),
    .o_stat_dout  (statDout),
    .o_stat_oe    (statOe),
    .o_stopped    (stopped),
    .o_eng_reset  (engReset),
`ifdef COLL_IRQ_EN
    .o_coll_irq   (collIrq),
`endif
    .o_coll_count (collCount)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] mkStat(input logic stp, input logic abt,
                                                input logic [3:0] cause, input logic [1:0] cnt);
    logic [DATA_W-1:0] s;
    s        = '0;
    s[0]     = stp;
    s[1]     = abt;
    s[5:2]   = cause;
    s[17:16] = cnt;
    return s;
  endfunction

  task automatic applyStimulus(input logic [3:0] req, input logic dw, input logic ld,
                               input logic [31:0] din, input logic ce, input logic rst);
    collReq = req;
    dWrite  = dw;
    stopLd  = ld;
    gpuDin  = din;
    clkEn   = ce;
    reset   = rst;
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] expStat,
                             input logic expEng);
    nameQ.push_back(name);
    statQ.push_back(expStat);
    flagQ.push_back({statRead, expEng});
  endtask

  task automatic doStep(input string name, input logic [3:0] req, input logic dw,
                        input logic ld, input logic [31:0] din, input logic ce,
                        input logic rst, input logic [DATA_W-1:0] expStat,
                        input logic expEng);
    applyStimulus(req, dw, ld, din, ce, rst);
    checkOutput(name, expStat, expEng);
    @(negedge clock);
  endtask

  // Monitor: everything queued before an edge is compared just after it.
  initial begin
    string             nm;
    logic [DATA_W-1:0] es;
    logic [1:0]        ef;
    forever begin
      @(posedge clock);
      #2;
      while (statQ.size() > 0) begin
        nm = nameQ.pop_front();
        es = statQ.pop_front();
        ef = flagQ.pop_front();
        checkCount++;
        if (statDout !== es || engReset !== ef[0] || statOe !== ef[1] ||
            stopped !== es[0] || collCount !== es[17:16]) begin
          errorCount++;
          $display("[TB] FAIL %s: got stat=%h eng=%b oe=%b stopped=%b count=%0d, expected stat=%h eng=%b oe=%b stopped=%b count=%0d",
                   nm, statDout, engReset, statOe, stopped, collCount,
                   es, ef[0], ef[1], es[0], es[17:16]);
        end
      end
    end
  end

  initial begin
    statRead = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clock);

    // Reset honoured with clk_en low; eng_reset follows xreset.
    doStep("reset",          4'b0000, 0, 0, 32'h00, 0, 1, mkStat(0,0,4'h0,0), 1);
    doStep("write_en0101",   4'b0000, 0, 1, 32'h14, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("stop_ch2",       4'b0100, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h4,1), 0);
    doStep("stopped_ign_ch0",4'b0001, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h4,1), 0);
    doStep("resume",         4'b0000, 0, 1, 32'h15, 1, 0, mkStat(0,0,4'h0,1), 0);
    statRead = 1'b0;
    doStep("idle_statrd0",   4'b0000, 0, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,1), 0);
    statRead = 1'b1;

    // Abort+resume together: abort wins, two enabled cycles of eng_reset.
    doStep("stop_ch0",       4'b0001, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h1,2), 0);
    doStep("abort_cyc1",     4'b0000, 0, 1, 32'h17, 1, 0, mkStat(1,1,4'h1,2), 1);
    doStep("abort_cyc2",     4'b0100, 1, 1, 32'h15, 1, 0, mkStat(1,1,4'h1,2), 1);
    doStep("abort_done",     4'b0000, 0, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,2), 0);

    // Held hit on ch1 fires once; clk_en low freezes everything.
    doStep("write_en0010",   4'b0000, 0, 1, 32'h08, 1, 0, mkStat(0,0,4'h0,2), 0);
    doStep("held_stop",      4'b0010, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h2,3), 0);
    doStep("held_stopped",   4'b0010, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h2,3), 0);
    doStep("frozen_stopped", 4'b0010, 1, 1, 32'h0B, 0, 0, mkStat(1,0,4'h2,3), 0);
    doStep("held_resume",    4'b0010, 1, 1, 32'h09, 1, 0, mkStat(0,0,4'h0,3), 0);
    doStep("held_no_refire", 4'b0010, 1, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,3), 0);
    doStep("frozen_idle1",   4'b0010, 1, 0, 32'h00, 0, 0, mkStat(0,0,4'h0,3), 0);
    doStep("frozen_idle2",   4'b0010, 1, 1, 32'h09, 0, 0, mkStat(0,0,4'h0,3), 0);
    doStep("held_after_en",  4'b0010, 1, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,3), 0);
    doStep("release",        4'b0000, 0, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,3), 0);

    // Counter saturation, then clear racing an increment.
    doStep("saturate",       4'b0010, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h2,3), 0);
    doStep("resume_sat",     4'b0000, 0, 1, 32'h09, 1, 0, mkStat(0,0,4'h0,3), 0);
    doStep("clear_vs_inc",   4'b0010, 1, 1, 32'h48, 1, 0, mkStat(1,0,4'h2,0), 0);
    doStep("resume_clr",     4'b0000, 0, 1, 32'h09, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("count_again",    4'b0010, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'h2,1), 0);

    // Reset during abort ends the pulse and clears enables and counter.
    doStep("abort_start",    4'b0000, 0, 1, 32'h0A, 1, 0, mkStat(1,1,4'h2,1), 1);
    doStep("reset_in_abort", 4'b0000, 0, 0, 32'h00, 1, 1, mkStat(0,0,4'h0,0), 1);
    doStep("post_reset",     4'b0000, 0, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("en_cleared",     4'b1111, 1, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("en_load_late",   4'b1111, 1, 1, 32'h3C, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("no_dwrite",      4'b1111, 0, 0, 32'h00, 1, 0, mkStat(0,0,4'h0,0), 0);
    doStep("all_edges",      4'b1111, 1, 0, 32'h00, 1, 0, mkStat(1,0,4'hF,1), 0);
    doStep("final_resume",   4'b0000, 0, 1, 32'h3D, 1, 0, mkStat(0,0,4'h0,1), 0);

    repeat (3) @(negedge clock);
    checkCount++;
    if (statQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", statQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/blit_coll_stop_ctrl.md
Name: blit_coll_stop_ctrl

Overview:
- Parametrised successor to the blitter collision-stop logic: NCH independent collision channels, each with its own enable and its own sticky cause flag.
- Adds a saturating collision counter and a multi-cycle engine abort reset; the GPU issues resume and abort commands.
- Sits between the blitter data-path comparators (per-channel write-inhibit terms) and the blitter state machines, which it stalls or resets.
- Status is read back onto the GPU data bus through a tristate-enable pair.

Parameters:
- NCH, 4: number of collision channels (1..8).
- CNT_W, 8: width of the collision counter (1..16).
- ABORT_LEN, 2: eng_reset pulse length in enabled cycles (>=1).
- DATA_W, 32: GPU data bus width (>= 2+NCH+1, and >= 16+CNT_W).

Ports:
- sys_clk  in  1  single system clock.
- xreset  in  1  synchronous, active-high reset.
- clk_en  in  1  cycle enable (blitter tick); all state advances only when high.
- coll_req  in  NCH  per-channel write-inhibit ("nowrite") request from the comparators.
- dwrite  in  1  blitter data-write phase strobe.
- gpu_din  in  DATA_W  GPU write data.
- stopld  in  1  control-register write strobe.
- statrd  in  1  status read select.
- stat_dout  out  DATA_W  status word.
- stat_oe  out  1  equals statrd (tristate enable).
- stopped  out  1  blitter stall request.
- eng_reset  out  1  active-high blitter engine reset: xreset OR abort pulse.
- coll_count  out  CNT_W  collision counter.

Behaviour:
- Control word, sampled when stopld=1 and clk_en=1:
  - bit0: resume.
  - bit1: abort.
  - bits[2+NCH-1:2]: channel enables; loaded on every stopld, in any state.
  - bit[2+NCH]: clear counter.
- Status word (combinational from registers):
  - bit0: stopped.
  - bit1: aborting.
  - bits[2+NCH-1:2]: cause flags.
  - bits[16+CNT_W-1:16]: coll_count.
  - all other bits 0.
- Per-channel qualification:
  - hit[i] = coll_req[i] & en[i] & dwrite.
  - hit_d[i] is registered on clk_en.
  - edge[i] = hit[i] & ~hit_d[i].
  - A held hit produces exactly one edge.
- States: IDLE, STOPPED, ABORT.
- IDLE:
  - Any edge -> STOPPED on the next enabled cycle.
  - cause <= edge (every channel edging that cycle is flagged).
  - Counter increments by 1 and saturates at all-ones.
  - resume/abort commands received in IDLE are ignored.
- STOPPED:
  - stopped=1; new edges are ignored (no count, no cause change).
  - hit_d keeps tracking.
  - abort -> ABORT; cause flags are held.
  - resume (without abort) -> IDLE; cause is cleared.
  - resume and abort together: abort wins.
- ABORT:
  - aborting=1, stopped=1, eng_reset=1 for exactly ABORT_LEN enabled cycles, then -> IDLE with cause cleared.
  - Edges are ignored.
  - stopld loads enables/clear but its commands are ignored.
- Counter clear:
  - A clear and an increment in the same cycle give a result of 0.
- Output latency:
  - stopped rises one enabled cycle after the edge.
  - eng_reset rises one enabled cycle after the abort write.
- Reset (xreset=1, honoured regardless of clk_en):
  - State goes to IDLE; en, cause, hit_d, coll_count and abort timer all go to 0.
  - stopped=0; eng_reset=1 combinationally while xreset is high.
  - Reset mid-abort ends the pulse immediately.
- clk_en=0: every register holds; outputs remain stable.

Optional Feature:
- COLL_IRQ_EN defined:
  - Adds output coll_irq (1 bit) and control bit[3+NCH] irq_mask, with reset value 0.
  - coll_irq pulses high for one enabled cycle on each IDLE->STOPPED transition when irq_mask=1.
  - Status bit[3+NCH] reflects irq_mask.
- Undefined: no port, no mask bit, and that status bit reads 0.

Decomposition:
- Package blit_stop_pkg holds:
  - state enum (IDLE/STOPPED/ABORT);
  - control bit indices (RESUME_B=0, ABORT_B=1, EN_LSB=2);
  - status indices (STAT_STOPPED=0, STAT_ABORTING=1, CAUSE_LSB=2, CNT_LSB=16).
- One sub-module, blit_coll_edge: per-channel qualify, delay register and edge detect, instantiated NCH times via generate.

Test Plan:
- Reset, then write en=4'b0101; pulse coll_req[2] with dwrite=1 -> stopped=1 next cycle, cause=4'b0100, coll_count=1.
- While STOPPED, pulse coll_req[0] -> no change; then write resume -> stopped=0 next cycle, cause=0, count stays 1.
- Stop on ch0; write abort+resume together -> eng_reset high for exactly ABORT_LEN=2 cycles, aborting=1 throughout, then IDLE, stopped=0.
- Hold coll_req[1]&dwrite high 10 cycles with en[1]=1 -> exactly one stop, count=1; toggle clk_en low mid-sequence -> all outputs frozen.
- CNT_W=2: cause 5 collisions with a resume after each -> coll_count saturates at 3; write clear in the same cycle as an edge -> count=0.
- Assert xreset during ABORT -> next cycle state IDLE, count=0, en=0; eng_reset high only while xreset is high.
